// File: rtl/bwn_accumulator_if.sv
// bwn_accumulator_if: activation stream in, saturated sum out, for the BWN MAC stage
interface bwn_accumulator_if #(
    parameter int WL = 8,
    parameter int AL = 16,
    parameter int N  = 9
);
    localparam int CW = $clog2(N);
    logic                 iSTART;
    logic                 iVALID;
    logic signed [WL-1:0] iDATA;
    logic                 iW;
    logic                 oBUSY;
    logic [CW-1:0]        oCNT;
    logic signed [AL-1:0] oDATA;
    logic                 oVALID;
    logic                 oSTART_FWD;
    modport slave (input iSTART, iVALID, iDATA, iW, output oBUSY, oCNT, oDATA, oVALID, oSTART_FWD);
    modport master (output iSTART, iVALID, iDATA, iW, input oBUSY, oCNT, oDATA, oVALID, oSTART_FWD);
endinterface

// File: rtl/bwn_accumulator.sv
// bwn_accumulator: binary-weight MAC, sums N signed +/-x terms and emits one saturated result
module bwn_accumulator #(
    parameter int WL = 8,
    parameter int AL = 16,
    parameter int N  = 9
) (
    input logic iCLK,
    input logic iRSTn,
    bwn_accumulator_if.slave bus
);
    localparam int CW = $clog2(N);
    localparam int AW = WL + 1 + CW;
    localparam int XW = (AW > AL ? AW : AL) + 1;
    localparam logic signed [XW-1:0] SMAX = {{(XW-AL+1){1'b0}}, {(AL-1){1'b1}}};
    localparam logic signed [XW-1:0] SMIN = {{(XW-AL+1){1'b1}}, {(AL-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t               state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [AL-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 start_q;

    // Term is widened by one bit before negation so -(-2^(WL-1)) is exact
    logic signed [WL:0]   xe, t;
    logic signed [AW-1:0] sum;
    logic signed [XW-1:0] sx;
    logic signed [AL-1:0] sat;

    assign xe  = {bus.iDATA[WL-1], bus.iDATA};
    assign t   = bus.iW ? xe : -xe;
    assign sum = acc_q + {{(AW-WL-1){t[WL]}}, t};
    assign sx  = {{(XW-AW){sum[AW-1]}}, sum};
    assign sat = sx > SMAX ? SMAX[AL-1:0] : sx < SMIN ? SMIN[AL-1:0] : sx[AL-1:0];

    // Next-state: iSTART overrides everything, including the final element of a sum
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (bus.iSTART) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (state_q == ACC && bus.iVALID) begin
            acc_d = sum;
            if (cnt_q == CW'(N - 1)) begin
                state_d = DONE;
                cnt_d   = '0;
                data_d  = sat;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State and output registers; reset discards any partial sum
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            start_q <= bus.iSTART;
        end
    end

    assign bus.oBUSY      = state_q == ACC;
    assign bus.oCNT       = cnt_q;
    assign bus.oDATA      = data_q;
    assign bus.oVALID     = valid_q;
    assign bus.oSTART_FWD = start_q;
endmodule

// File: tb/tb_bwn_accumulator.sv
// tb_bwn_accumulator: directed checks of accumulation, saturation, abort and restart
module tb_bwn_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bwn_accumulator_if #(.WL(8), .AL(16), .N(4)) di();
    bwn_accumulator_if #(.WL(8), .AL(8), .N(4)) si();

    bwn_accumulator #(.WL(8), .AL(16), .N(4)) ud (.iCLK(clk), .iRSTn(rst_n), .bus(di));
    bwn_accumulator #(.WL(8), .AL(8), .N(4)) us (.iCLK(clk), .iRSTn(rst_n), .bus(si));

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fd(input int x, input logic w);
        di.iVALID = 1'b1;
        di.iDATA  = 8'(x);
        di.iW     = w;
        cyc();
        di.iVALID = 1'b0;
    endtask

    task automatic sd(input int x, input logic w);
        si.iVALID = 1'b1;
        si.iDATA  = 8'(x);
        si.iW     = w;
        cyc();
        si.iVALID = 1'b0;
    endtask

    task automatic dst;
        di.iSTART = 1'b1;
        cyc();
        di.iSTART = 1'b0;
    endtask

    task automatic sst;
        si.iSTART = 1'b1;
        cyc();
        si.iSTART = 1'b0;
    endtask

    initial begin
        di.iSTART = 0; di.iVALID = 0; di.iDATA = 0; di.iW = 0;
        si.iSTART = 0; si.iVALID = 0; si.iDATA = 0; si.iW = 0;
        #1;
        chk("rst_data", $signed(di.oDATA), 0);
        chk("rst_valid", di.oVALID, 0);
        chk("rst_busy", di.oBUSY, 0);
        chk("rst_cnt", di.oCNT, 0);
        chk("rst_fwd", di.oSTART_FWD, 0);
        #20 rst_n = 1'b1;
        cyc();
        // partial sum then async reset mid-cycle
        dst();
        chk("start_busy", di.oBUSY, 1);
        chk("start_fwd", di.oSTART_FWD, 1);
        fd(10, 1);
        fd(10, 1);
        chk("mid_cnt", di.oCNT, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt", di.oCNT, 0);
        chk("arst_busy", di.oBUSY, 0);
        #1 rst_n = 1'b1;
        cyc();
        // 4 x 10 = 40
        dst();
        fd(10, 1); fd(10, 1); fd(10, 1);
        chk("pre_valid", di.oVALID, 0);
        fd(10, 1);
        chk("sum40_valid", di.oVALID, 1);
        chk("sum40_data", $signed(di.oDATA), 40);
        chk("done_cnt", di.oCNT, 0);
        cyc();
        chk("sum40_pulse", di.oVALID, 0);
        // mixed signs with gaps: 5+3-7+128 = 129
        dst();
        fd(5, 1);
        cyc(); cyc();
        chk("gap_cnt", di.oCNT, 1);
        chk("gap_busy", di.oBUSY, 1);
        fd(-3, 0);
        cyc();
        fd(7, 0);
        cyc(); cyc(); cyc();
        fd(-128, 0);
        chk("mix_valid", di.oVALID, 1);
        chk("mix_data", $signed(di.oDATA), 129);
        cyc();
        chk("mix_pulse", di.oVALID, 0);
        chk("mix_busy", di.oBUSY, 0);
        // abort on the 4th element
        dst();
        fd(1, 1); fd(1, 1); fd(1, 1);
        chk("abort_cnt3", di.oCNT, 3);
        di.iSTART = 1'b1;
        fd(50, 1);
        di.iSTART = 1'b0;
        chk("abort_valid", di.oVALID, 0);
        chk("abort_hold", $signed(di.oDATA), 129);
        chk("abort_cnt", di.oCNT, 0);
        fd(1, 1); fd(1, 1); fd(1, 1); fd(1, 1);
        chk("post_abort_valid", di.oVALID, 1);
        chk("post_abort_data", $signed(di.oDATA), 4);
        cyc();
        // IDLE ignores iVALID
        fd(5, 1); fd(5, 1); fd(5, 1);
        chk("idle_cnt", di.oCNT, 0);
        chk("idle_busy", di.oBUSY, 0);
        cyc();
        chk("idle_valid", di.oVALID, 0);
        chk("idle_data", $signed(di.oDATA), 4);
        chk("fwd_before", di.oSTART_FWD, 0);
        dst();
        chk("fwd_pulse", di.oSTART_FWD, 1);
        cyc();
        chk("fwd_after", di.oSTART_FWD, 0);
        // 4 x -(3) = -12, then restart in the DONE cycle
        fd(3, 0); fd(3, 0); fd(3, 0); fd(3, 0);
        chk("neg_data", $signed(di.oDATA), -12);
        dst();
        chk("b2b_valid", di.oVALID, 0);
        chk("b2b_busy", di.oBUSY, 1);
        chk("b2b_hold", $signed(di.oDATA), -12);
        fd(20, 1); fd(20, 1); fd(20, 1);
        chk("b2b_hold2", $signed(di.oDATA), -12);
        fd(-20, 0);
        chk("b2b_valid2", di.oVALID, 1);
        chk("b2b_data", $signed(di.oDATA), 80);
        cyc();
        // saturation with AL=8
        sst();
        sd(127, 1); sd(127, 1); sd(127, 1); sd(127, 1);
        chk("sat_pos_valid", si.oVALID, 1);
        chk("sat_pos", $signed(si.oDATA), 127);
        cyc();
        sst();
        sd(-128, 1); sd(-128, 1); sd(-128, 1); sd(-128, 1);
        chk("sat_neg", $signed(si.oDATA), -128);
        cyc();
        sst();
        sd(-128, 0); sd(-128, 0); sd(-128, 0); sd(-128, 0);
        chk("sat_negneg", $signed(si.oDATA), 127);
        cyc();
        sst();
        sd(31, 1); sd(32, 1); sd(32, 1); sd(32, 1);
        chk("edge_max", $signed(si.oDATA), 127);
        cyc();
        sst();
        sd(32, 1); sd(32, 1); sd(-32, 0); sd(32, 1);
        chk("just_over", $signed(si.oDATA), 127);
        cyc();
        sst();
        sd(-32, 1); sd(-32, 1); sd(32, 0); sd(-32, 1);
        chk("edge_min", $signed(si.oDATA), -128);
        cyc();
        sst();
        sd(-50, 1); sd(20, 0); sd(7, 1); sd(-1, 0);
        chk("mid_range", $signed(si.oDATA), -62);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bwn_accumulator.md
Name: bwn_accumulator

Overview:
Binary-weight MAC stage for the BWN datapath. It accumulates a signed activation stream. For each element, a 1-bit weight selects add (+x) or subtract (-x). After N accepted elements it emits one saturated signed sum with a single-cycle valid pulse. It sits directly upstream of the datapath holding register: oVALID drives that register's enable, and oSTART_FWD drives its clear.

Parameters:
WL, 8, activation width (signed two's complement)
AL, 16, output sum width (signed); the sum saturates to this range
N, 9, elements per sum (e.g. 3x3 kernel); legal range 2..1024

Ports:
iCLK  input  1  clock, rising edge
iRSTn  input  1  asynchronous active-low reset
iSTART  input  1  synchronous clear/begin new sum; highest priority after reset
iVALID  input  1  iDATA/iW valid this cycle
iDATA  input  WL  signed activation
iW  input  1  weight sign: 1 = +iDATA, 0 = -iDATA
oBUSY  output  1  high while in ACC state
oCNT  output  clog2(N)  elements accepted in the current sum
oDATA  output  AL  saturated signed sum; holds until next result or clear
oVALID  output  1  one-cycle pulse, oDATA newly updated
oSTART_FWD  output  1  iSTART delayed one cycle (downstream register clear)

Behaviour:
- Reset (iRSTn=0, async): state=IDLE, internal acc=0, oCNT=0, oDATA=0, oVALID=0, oBUSY=0, oSTART_FWD=0. Effect is immediate, with no clock needed. Reset mid-sum discards the partial sum.
- Internal acc width: WL+1+clog2(N) bits, which cannot overflow. Each term is sign-extended to WL+1 bits before negation, so -(-2^(WL-1)) = +2^(WL-1) exactly.
- States:
  - IDLE: iVALID ignored; iSTART -> ACC with acc=0, cnt=0.
  - ACC: on iVALID, acc += iW ? x : -x and cnt++. If cnt==N-1 on an accepted element -> DONE.
  - DONE: one cycle only; oDATA/oVALID are updated on the transition into DONE; then -> IDLE. iVALID in DONE is ignored.
- Output latency: oVALID=1 and oDATA=sat(final acc) are registered on the clock edge that accepts element N. They are visible the cycle after element N is presented, for exactly one cycle.
- Saturation: if final acc > 2^(AL-1)-1, then oDATA = 2^(AL-1)-1. If final acc < -2^(AL-1), then oDATA = -2^(AL-1). Otherwise oDATA = acc truncated to AL bits, with no change in value.
- iSTART in any state: acc=0, cnt=0, next state=ACC, oVALID=0 next cycle. iSTART with iVALID in the same cycle: the element is dropped. iSTART on the cycle that would accept element N: the sum is aborted, with no oVALID and oDATA unchanged.
- oDATA is held between results; it is not cleared by iSTART.
- oCNT: 0 in IDLE and after iSTART; resets to 0 on entering DONE.
- Gaps: iVALID may drop for any number of cycles in ACC; acc and cnt hold.
- oSTART_FWD: registered copy of iSTART; 0 after reset.

Test Plan:
- Reset/hold: with WL=8/AL=16/N=4, assert iRSTn=0 mid-sum after 2 elements -> all outputs 0 immediately. Release, pulse iSTART, feed 4x(x=10,w=1) -> oVALID pulse one cycle after the 4th element, oDATA=40.
- Mixed signs with gaps: N=4, x={5,-3,7,-128}, w={1,0,0,0}, with idle cycles between elements -> oDATA=5+3-7+128=129, one oVALID pulse, oBUSY low afterwards.
- Saturation: AL=8, N=4, 4x(x=127,w=1) -> oDATA=127. Then 4x(x=-128,w=1) -> oDATA=-128. 4x(x=-128,w=0) -> 127.
- Abort: N=4, after 3 elements assert iSTART together with iVALID on the 4th -> no oVALID, oDATA keeps its prior value. The next 4 elements of x=1,w=1 -> oDATA=4.
- IDLE ignore: iVALID pulses with no iSTART -> no oVALID, oCNT stays 0. oSTART_FWD mirrors an iSTART pulse exactly one cycle later.
- Back-to-back: iSTART asserted in the DONE cycle -> new sum starts. The next N elements produce a correct independent result, and the previous oDATA is held until then.
